// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch/execute sequencer.
// Holds the controller state encoding, the instruction CLASS and branch
// COND codes, the fixed ALU opcodes used during fetch, the default ALU
// operand select, and the packed bundle of datapath strobes.
package cpu_pkg;

    typedef enum logic [3:0] {
        F_MAR,
        F_INC,
        F_WAIT,
        F_IR,
        DECODE,
        X_ALU,
        X_ADDR,
        X_MBR,
        M_WAIT,
        X_WB,
        X_BR,
        HALT,
        FAULT
    } state_e;

    localparam logic [2:0] CLASS_ALU    = 3'b000;
    localparam logic [2:0] CLASS_LOAD   = 3'b001;
    localparam logic [2:0] CLASS_STORE  = 3'b010;
    localparam logic [2:0] CLASS_BRANCH = 3'b011;
    localparam logic [2:0] CLASS_HALT   = 3'b111;

    localparam logic [3:0] COND_ALWAYS = 4'b0000;
    localparam logic [3:0] COND_Z      = 4'b0001;
    localparam logic [3:0] COND_NZ     = 4'b0010;
    localparam logic [3:0] COND_C      = 4'b0011;
    localparam logic [3:0] COND_NC     = 4'b0100;
    localparam logic [3:0] COND_N      = 4'b0101;
    localparam logic [3:0] COND_NN     = 4'b0110;
    localparam logic [3:0] COND_V      = 4'b0111;

    localparam logic [4:0] OPC_PASS = 5'b10010;
    localparam logic [4:0] OPC_INC  = 5'b10001;

    localparam logic [3:0] CU_PC = 4'hF;

    // One bit per datapath strobe, kept together so they register as a unit.
    typedef struct packed {
        logic marLoad;
        logic pcLoad;
        logic irLoad;
        logic mbrLoad;
        logic mbrStore;
        logic rfLoad;
        logic srLoad;
        logic aluStore;
        logic mfa;
        logic readWrite;
        logic wordByte;
    } strobes_t;

endpackage

// File: rtl/cond_eval.sv
// Branch condition evaluator.
// Ports:
//   cond_i  - 4-bit COND field of the instruction
//   sr_i    - status flags {N,Z,C,V}
//   taken_o - 1 when the branch condition holds
// Codes above V are reserved and never take the branch.
module cond_eval
    import cpu_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] sr_i,
    output logic       taken_o
);

    logic flagN;
    logic flagZ;
    logic flagC;
    logic flagV;

    assign flagN = sr_i[3];
    assign flagZ = sr_i[2];
    assign flagC = sr_i[1];
    assign flagV = sr_i[0];

    always_comb begin
        taken_o = 1'b0;
        case (cond_i)
            COND_ALWAYS: taken_o = 1'b1;
            COND_Z:      taken_o = flagZ;
            COND_NZ:     taken_o = ~flagZ;
            COND_C:      taken_o = flagC;
            COND_NC:     taken_o = ~flagC;
            COND_N:      taken_o = flagN;
            COND_NN:     taken_o = ~flagN;
            COND_V:      taken_o = flagV;
            default:     taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Microsequencer for a simple load/store CPU: fetches an instruction,
// decodes its CLASS and walks the ALU / LOAD / STORE / BRANCH / HALT paths,
// driving the datapath strobes. Memory waits are bounded by MFC_TIMEOUT;
// running out of time parks the controller in FAULT until Reset.
// Ports:
//   Clk, Reset        - falling-edge clock, asynchronous active-high reset
//   MFC               - memory function complete
//   IR, SR            - current instruction, status flags {N,Z,C,V}
//   MARLOAD..WORD_BYTE- datapath strobes (READ_WRITE=1 means read)
//   opcode, CU        - ALU operation and operand select
//   Busy, Fault       - running indicator, memory timeout indicator
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int OPC_W       = 5,
    parameter int MFC_TIMEOUT = 15
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              MFC,
    input  logic [DATA_W-1:0] IR,
    input  logic [3:0]        SR,
    output logic              MARLOAD,
    output logic              PCLOAD,
    output logic              IRLOAD,
    output logic              MBRLOAD,
    output logic              MBRSTORE,
    output logic              RFLOAD,
    output logic              SRLOAD,
    output logic              ALUSTORE,
    output logic              MFA,
    output logic              READ_WRITE,
    output logic              WORD_BYTE,
    output logic [OPC_W-1:0]  opcode,
    output logic [3:0]        CU,
    output logic              Busy,
    output logic              Fault
);

    localparam int CNT_W = $clog2(MFC_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(MFC_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [OPC_W-1:0] OPC_PASS_W = OPC_W'(OPC_PASS);
    localparam logic [OPC_W-1:0] OPC_INC_W  = OPC_W'(OPC_INC);

    logic [2:0]       irClass;
    logic [3:0]       irCond;
    logic [OPC_W-1:0] irOp;
    logic             unusedIrLow;
    logic             condTaken;

    assign irClass     = IR[DATA_W-1 -: 3];
    assign irCond      = IR[DATA_W-4 -: 4];
    assign irOp        = IR[DATA_W-8 -: OPC_W];
    assign unusedIrLow = ^IR[DATA_W-8-OPC_W:0];

    cond_eval u_condEval (
        .cond_i  (irCond),
        .sr_i    (SR),
        .taken_o (condTaken)
    );

    state_e           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             memWrite_q, memWrite_d;
    logic             started_q,  started_d;
    strobes_t         strobes_q,  strobes_d;
    logic [OPC_W-1:0] opcode_q,   opcode_d;
    logic [3:0]       cu_q,       cu_d;
    logic             busy_q,     busy_d;
    logic             fault_q,    fault_d;

    // Next-state logic. The first edge after reset only loads the F_MAR
    // outputs (started_q is still 0), so F_MAR is seen for a full cycle.
    // In a wait state MFC is checked before the timeout, so a completion
    // arriving on the last allowed cycle is honoured.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        memWrite_d = memWrite_q;
        started_d  = 1'b1;
        case (state_q)
            F_MAR: state_d = started_q ? F_INC : F_MAR;
            F_INC: begin
                state_d = F_WAIT;
                cnt_d   = '0;
            end
            F_WAIT: begin
                if (MFC) begin
                    state_d = F_IR;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) state_d = FAULT;
                end
            end
            F_IR: state_d = DECODE;
            DECODE: begin
                case (irClass)
                    CLASS_ALU:    state_d = X_ALU;
                    CLASS_LOAD: begin
                        state_d    = X_ADDR;
                        memWrite_d = 1'b0;
                    end
                    CLASS_STORE: begin
                        state_d    = X_ADDR;
                        memWrite_d = 1'b1;
                    end
                    CLASS_BRANCH: state_d = condTaken ? X_BR : F_MAR;
                    CLASS_HALT:   state_d = HALT;
                    default:      state_d = F_MAR;
                endcase
            end
            X_ALU: state_d = F_MAR;
            X_ADDR: begin
                state_d = memWrite_q ? X_MBR : M_WAIT;
                cnt_d   = '0;
            end
            X_MBR: begin
                state_d = M_WAIT;
                cnt_d   = '0;
            end
            M_WAIT: begin
                if (MFC) begin
                    state_d = memWrite_q ? F_MAR : X_WB;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) state_d = FAULT;
                end
            end
            X_WB:  state_d = F_MAR;
            X_BR:  state_d = F_MAR;
            HALT:  state_d = HALT;
            FAULT: state_d = FAULT;
            default: state_d = F_MAR;
        endcase
    end

    // Output decode of the state being entered, so the registered outputs
    // line up with the state register in the same cycle.
    always_comb begin
        strobes_d = '0;
        opcode_d  = OPC_PASS_W;
        cu_d      = CU_PC;
        busy_d    = 1'b1;
        fault_d   = 1'b0;
        case (state_d)
            F_MAR: begin
                strobes_d.aluStore = 1'b1;
                strobes_d.marLoad  = 1'b1;
            end
            F_INC: begin
                strobes_d.aluStore  = 1'b1;
                strobes_d.pcLoad    = 1'b1;
                strobes_d.mfa       = 1'b1;
                strobes_d.readWrite = 1'b1;
                strobes_d.wordByte  = 1'b1;
                opcode_d            = OPC_INC_W;
            end
            F_WAIT: begin
                strobes_d.mfa       = 1'b1;
                strobes_d.readWrite = 1'b1;
                strobes_d.wordByte  = 1'b1;
            end
            F_IR: begin
                strobes_d.irLoad   = 1'b1;
                strobes_d.mbrStore = 1'b1;
            end
            X_ALU: begin
                strobes_d.aluStore = 1'b1;
                strobes_d.rfLoad   = 1'b1;
                strobes_d.srLoad   = 1'b1;
                opcode_d           = irOp;
                cu_d               = irCond;
            end
            X_ADDR: begin
                strobes_d.aluStore = 1'b1;
                strobes_d.marLoad  = 1'b1;
                opcode_d           = irOp;
            end
            X_MBR: strobes_d.mbrLoad = 1'b1;
            M_WAIT: begin
                strobes_d.mfa       = 1'b1;
                strobes_d.readWrite = ~memWrite_d;
                strobes_d.wordByte  = 1'b1;
            end
            X_WB: begin
                strobes_d.mbrStore = 1'b1;
                strobes_d.rfLoad   = 1'b1;
            end
            X_BR: begin
                strobes_d.aluStore = 1'b1;
                strobes_d.pcLoad   = 1'b1;
                opcode_d           = irOp;
            end
            HALT: busy_d = 1'b0;
            FAULT: begin
                busy_d  = 1'b0;
                fault_d = 1'b1;
            end
            default: ;
        endcase
    end

    // State and output registers. Reset clears every strobe immediately,
    // which also drops a pending MFA when a wait is aborted.
    always_ff @(negedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= F_MAR;
            cnt_q      <= '0;
            memWrite_q <= 1'b0;
            started_q  <= 1'b0;
            strobes_q  <= '0;
            opcode_q   <= OPC_PASS_W;
            cu_q       <= '0;
            busy_q     <= 1'b1;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            memWrite_q <= memWrite_d;
            started_q  <= started_d;
            strobes_q  <= strobes_d;
            opcode_q   <= opcode_d;
            cu_q       <= cu_d;
            busy_q     <= busy_d;
            fault_q    <= fault_d;
        end
    end

    assign MARLOAD    = strobes_q.marLoad;
    assign PCLOAD     = strobes_q.pcLoad;
    assign IRLOAD     = strobes_q.irLoad;
    assign MBRLOAD    = strobes_q.mbrLoad;
    assign MBRSTORE   = strobes_q.mbrStore;
    assign RFLOAD     = strobes_q.rfLoad;
    assign SRLOAD     = strobes_q.srLoad;
    assign ALUSTORE   = strobes_q.aluStore;
    assign MFA        = strobes_q.mfa;
    assign READ_WRITE = strobes_q.readWrite;
    assign WORD_BYTE  = strobes_q.wordByte;
    assign opcode     = opcode_q;
    assign CU         = cu_q;
    assign Busy       = busy_q;
    assign Fault      = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer. Instructions are expanded into a
// per-cycle plan (expected outputs plus the MFC/IR/SR to drive) from the
// instruction-level rules; the stimulus process drives the plan and queues
// expectations, and a monitor on the rising edge pops and compares.
module tb_fetch_sequencer;

    localparam int DATA_W  = 32;
    localparam int OPC_W   = 5;
    localparam int TIMEOUT = 4;

    // Strobe bit order: {MARLOAD,PCLOAD,IRLOAD,MBRLOAD,MBRSTORE,RFLOAD,SRLOAD,ALUSTORE,MFA,READ_WRITE,WORD_BYTE}
    localparam logic [10:0] M_MARLOAD  = 11'b100_0000_0000;
    localparam logic [10:0] M_PCLOAD   = 11'b010_0000_0000;
    localparam logic [10:0] M_IRLOAD   = 11'b001_0000_0000;
    localparam logic [10:0] M_MBRLOAD  = 11'b000_1000_0000;
    localparam logic [10:0] M_MBRSTORE = 11'b000_0100_0000;
    localparam logic [10:0] M_RFLOAD   = 11'b000_0010_0000;
    localparam logic [10:0] M_SRLOAD   = 11'b000_0001_0000;
    localparam logic [10:0] M_ALUSTORE = 11'b000_0000_1000;
    localparam logic [10:0] M_MFA      = 11'b000_0000_0100;
    localparam logic [10:0] M_RW       = 11'b000_0000_0010;
    localparam logic [10:0] M_WB       = 11'b000_0000_0001;

    localparam int P_RESET = 0;
    localparam int P_FMAR  = 1;
    localparam int P_FINC  = 2;
    localparam int P_FWAIT = 3;
    localparam int P_FIR   = 4;
    localparam int P_DEC   = 5;
    localparam int P_XALU  = 6;
    localparam int P_XADDR = 7;
    localparam int P_XMBR  = 8;
    localparam int P_MRD   = 9;
    localparam int P_MWR   = 10;
    localparam int P_XWB   = 11;
    localparam int P_XBR   = 12;
    localparam int P_HALT  = 13;
    localparam int P_FAULT = 14;

    typedef struct packed {
        logic [3:0]  phase;
        logic [10:0] strobes;
        logic [4:0]  opcode;
        logic [3:0]  cu;
        logic        busy;
        logic        fault;
    } exp_t;

    typedef struct packed {
        exp_t        e;
        logic        mfc;
        logic [31:0] ir;
        logic [3:0]  sr;
    } step_t;

    logic Clk;
    logic Reset;
    logic MFC;
    logic [DATA_W-1:0] IR;
    logic [3:0] SR;
    logic MARLOAD, PCLOAD, IRLOAD, MBRLOAD, MBRSTORE, RFLOAD, SRLOAD;
    logic ALUSTORE, MFA, READ_WRITE, WORD_BYTE;
    logic [OPC_W-1:0] opcode;
    logic [3:0] CU;
    logic Busy;
    logic Fault;

    exp_t  sbQ[$];
    step_t plan[$];
    int    checks = 0;
    int    errors = 0;

    logic [31:0] curIr;
    logic [3:0]  curSr;
    logic [4:0]  curOp;
    logic [3:0]  curCond;

    fetch_sequencer #(
        .DATA_W      (DATA_W),
        .OPC_W       (OPC_W),
        .MFC_TIMEOUT (TIMEOUT)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .MFC        (MFC),
        .IR         (IR),
        .SR         (SR),
        .MARLOAD    (MARLOAD),
        .PCLOAD     (PCLOAD),
        .IRLOAD     (IRLOAD),
        .MBRLOAD    (MBRLOAD),
        .MBRSTORE   (MBRSTORE),
        .RFLOAD     (RFLOAD),
        .SRLOAD     (SRLOAD),
        .ALUSTORE   (ALUSTORE),
        .MFA        (MFA),
        .READ_WRITE (READ_WRITE),
        .WORD_BYTE  (WORD_BYTE),
        .opcode     (opcode),
        .CU         (CU),
        .Busy       (Busy),
        .Fault      (Fault)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic string phaseName(input logic [3:0] ph);
        case (int'(ph))
            P_RESET: return "reset";
            P_FMAR:  return "F_MAR";
            P_FINC:  return "F_INC";
            P_FWAIT: return "F_WAIT";
            P_FIR:   return "F_IR";
            P_DEC:   return "DECODE";
            P_XALU:  return "X_ALU";
            P_XADDR: return "X_ADDR";
            P_XMBR:  return "X_MBR";
            P_MRD:   return "M_WAIT_rd";
            P_MWR:   return "M_WAIT_wr";
            P_XWB:   return "X_WB";
            P_XBR:   return "X_BR";
            P_HALT:  return "HALT";
            P_FAULT: return "FAULT";
            default: return "unknown";
        endcase
    endfunction

    // Expected outputs of one cycle, straight from the per-state output table.
    function automatic exp_t mkExp(input int ph, input logic [4:0] op, input logic [3:0] cond);
        exp_t e;
        e.phase   = 4'(ph);
        e.strobes = '0;
        e.opcode  = 5'b10010;
        e.cu      = 4'hF;
        e.busy    = 1'b1;
        e.fault   = 1'b0;
        case (ph)
            P_RESET: e.cu = 4'h0;
            P_FMAR:  e.strobes = M_ALUSTORE | M_MARLOAD;
            P_FINC: begin
                e.strobes = M_ALUSTORE | M_PCLOAD | M_MFA | M_RW | M_WB;
                e.opcode  = 5'b10001;
            end
            P_FWAIT: e.strobes = M_MFA | M_RW | M_WB;
            P_FIR:   e.strobes = M_IRLOAD | M_MBRSTORE;
            P_XALU: begin
                e.strobes = M_ALUSTORE | M_RFLOAD | M_SRLOAD;
                e.opcode  = op;
                e.cu      = cond;
            end
            P_XADDR: begin
                e.strobes = M_ALUSTORE | M_MARLOAD;
                e.opcode  = op;
            end
            P_XMBR:  e.strobes = M_MBRLOAD;
            P_MRD:   e.strobes = M_MFA | M_RW | M_WB;
            P_MWR:   e.strobes = M_MFA | M_WB;
            P_XWB:   e.strobes = M_MBRSTORE | M_RFLOAD;
            P_XBR: begin
                e.strobes = M_ALUSTORE | M_PCLOAD;
                e.opcode  = op;
            end
            P_HALT:  e.busy = 1'b0;
            P_FAULT: begin
                e.busy  = 1'b0;
                e.fault = 1'b1;
            end
            default: ;
        endcase
        return e;
    endfunction

    // Branch rule over the flags {N,Z,C,V}.
    function automatic bit condTrue(input logic [3:0] c, input logic [3:0] f);
        case (int'(c))
            0: return 1'b1;
            1: return f[2];
            2: return !f[2];
            3: return f[1];
            4: return !f[1];
            5: return f[3];
            6: return !f[3];
            7: return f[0];
            default: return 1'b0;
        endcase
    endfunction

    function automatic void addStep(input int ph, input logic mfc);
        step_t s;
        s.e   = mkExp(ph, curOp, curCond);
        s.mfc = mfc;
        s.ir  = curIr;
        s.sr  = curSr;
        plan.push_back(s);
    endfunction

    // Non-wait cycles get a random MFC, which the controller must ignore.
    function automatic void addNoisy(input int ph);
        addStep(ph, 1'($urandom_range(0, 1)));
    endfunction

    // A memory wait: dly idle cycles then MFC, or a timeout if dly is too long.
    function automatic bit addWait(input int ph, input int dly);
        if (dly >= TIMEOUT) begin
            for (int i = 0; i < TIMEOUT; i++) addStep(ph, 1'b0);
            for (int i = 0; i < 3; i++) addNoisy(P_FAULT);
            return 1'b1;
        end
        for (int i = 0; i < dly; i++) addStep(ph, 1'b0);
        addStep(ph, 1'b1);
        return 1'b0;
    endfunction

    function automatic void setInstr(input logic [2:0] cls, input logic [3:0] cond,
                                     input logic [4:0] op, input logic [3:0] sr,
                                     input logic [19:0] low);
        curIr   = {cls, cond, op, low};
        curSr   = sr;
        curOp   = op;
        curCond = cond;
    endfunction

    // Expands one instruction into its cycle plan; returns 1 if it ends in
    // HALT or FAULT and therefore needs a reset to continue.
    function automatic bit planInstr(input logic [2:0] cls, input logic [3:0] cond,
                                     input logic [4:0] op, input logic [3:0] sr,
                                     input int d1, input int d2, input logic [19:0] low);
        setInstr(cls, cond, op, sr, low);
        addNoisy(P_FMAR);
        addNoisy(P_FINC);
        if (addWait(P_FWAIT, d1)) return 1'b1;
        addNoisy(P_FIR);
        addNoisy(P_DEC);
        case (int'(cls))
            0: addNoisy(P_XALU);
            1: begin
                addNoisy(P_XADDR);
                if (addWait(P_MRD, d2)) return 1'b1;
                addNoisy(P_XWB);
            end
            2: begin
                addNoisy(P_XADDR);
                addNoisy(P_XMBR);
                if (addWait(P_MWR, d2)) return 1'b1;
            end
            3: if (condTrue(cond, sr)) addNoisy(P_XBR);
            7: begin
                for (int i = 0; i < 4; i++) addNoisy(P_HALT);
                return 1'b1;
            end
            default: ;
        endcase
        return 1'b0;
    endfunction

    // Drives the planned cycles and queues the matching expectations.
    task automatic applyStimulus();
        step_t s;
        while (plan.size() > 0) begin
            s = plan.pop_front();
            @(negedge Clk);
            #1;
            MFC = s.mfc;
            IR  = s.ir;
            SR  = s.sr;
            sbQ.push_back(s.e);
        end
    endtask

    task automatic applyReset();
        @(negedge Clk);
        #1;
        Reset = 1'b1;
        MFC   = 1'b0;
        sbQ.push_back(mkExp(P_RESET, 5'd0, 4'd0));
        @(negedge Clk);
        #1;
        sbQ.push_back(mkExp(P_RESET, 5'd0, 4'd0));
        @(posedge Clk);
        #1;
        Reset = 1'b0;
    endtask

    task automatic checkOutput(input exp_t e);
        logic [10:0] actStrobes;
        actStrobes = {MARLOAD, PCLOAD, IRLOAD, MBRLOAD, MBRSTORE, RFLOAD, SRLOAD,
                      ALUSTORE, MFA, READ_WRITE, WORD_BYTE};
        checks++;
        if ({actStrobes, opcode, CU, Busy, Fault} !== {e.strobes, e.opcode, e.cu, e.busy, e.fault}) begin
            errors++;
            $display("[TB] FAIL %s @%0t got strobes=%b opc=%b cu=%h busy=%b fault=%b expected strobes=%b opc=%b cu=%h busy=%b fault=%b",
                     phaseName(e.phase), $time, actStrobes, opcode, CU, Busy, Fault,
                     e.strobes, e.opcode, e.cu, e.busy, e.fault);
        end
    endtask

    // Monitor: one expectation per cycle, compared mid-cycle.
    always @(posedge Clk) begin
        if (sbQ.size() > 0) checkOutput(sbQ.pop_front());
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog got time %0t expected finish before 100000", $time);
        $fatal(1);
    end

    initial begin
        bit needReset;
        Reset = 1'b1;
        MFC   = 1'b0;
        IR    = '0;
        SR    = '0;
        applyReset();

        // ALU instruction 0x0040_0000 with immediate MFC.
        void'(planInstr(3'b000, 4'b0000, 5'b00100, 4'b0000, 0, 0, 20'h0));
        // LOAD with MFC three cycles late in both waits.
        void'(planInstr(3'b001, 4'b0000, 5'b00011, 4'b0000, 3, 3, 20'h12345));
        // STORE.
        void'(planInstr(3'b010, 4'b0000, 5'b01010, 4'b0000, 1, 0, 20'h0abcd));
        // Branch on Z, taken then not taken.
        void'(planInstr(3'b011, 4'b0001, 5'b00110, 4'b0100, 0, 0, 20'h0));
        void'(planInstr(3'b011, 4'b0001, 5'b00110, 4'b0000, 0, 0, 20'h0));
        // Undefined class behaves as a NOP.
        void'(planInstr(3'b101, 4'b0011, 5'b11111, 4'b1111, 0, 0, 20'h0));
        // MFC on the very last allowed wait cycle.
        void'(planInstr(3'b000, 4'b1001, 5'b01111, 4'b0000, TIMEOUT - 1, 0, 20'h0));
        applyStimulus();

        // Fetch timeout, then reset and resume.
        void'(planInstr(3'b000, 4'b0000, 5'b00001, 4'b0000, TIMEOUT, 0, 20'h0));
        applyStimulus();
        applyReset();

        // Memory-read timeout.
        void'(planInstr(3'b001, 4'b0000, 5'b00010, 4'b0000, 0, TIMEOUT, 20'h0));
        applyStimulus();
        applyReset();

        // HALT holds until reset.
        void'(planInstr(3'b111, 4'b0000, 5'b00000, 4'b0000, 0, 0, 20'h0));
        applyStimulus();
        applyReset();

        // Reset in the middle of a fetch wait.
        setInstr(3'b000, 4'b0000, 5'b00000, 4'b0000, 20'h0);
        addNoisy(P_FMAR);
        addNoisy(P_FINC);
        addStep(P_FWAIT, 1'b0);
        addStep(P_FWAIT, 1'b0);
        applyStimulus();
        applyReset();

        // Random instruction mix.
        for (int n = 0; n < 40; n++) begin
            needReset = planInstr(3'($urandom_range(0, 6)), 4'($urandom_range(0, 15)),
                                  5'($urandom()), 4'($urandom()),
                                  int'($urandom_range(0, TIMEOUT - 1)),
                                  int'($urandom_range(0, TIMEOUT - 1)), 20'($urandom()));
            applyStimulus();
            if (needReset) applyReset();
        end

        @(posedge Clk);
        #1;
        checks++;
        if (sbQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain got %0d pending expected 0", sbQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
